jcnt_rx: RTL

- Receive-side checker/decoder for the Johnson-counter code produced by jcnt.
- Samples a WIDTH-bit Johnson word each valid cycle and decodes it to a binary phase index.
- Locks onto the sequence after LOCK_CNT consecutive legal successors, then flags any deviation.
- Sits downstream of jcnt (or any Johnson-coded phase bus) as a sequence monitor and phase decoder.

---
 rtl/jcnt_pkg.sv | 46 ++++
 rtl/jcnt_code_decode.sv | 19 +
 rtl/jcnt_rx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jcnt_pkg.sv
// Shared definitions for Johnson-code receive logic: state encoding and code helpers.
// The helpers take the word zero-extended to 32 bits plus the real width.
package jcnt_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } jc_state_e;

  function automatic int jc_iw(input int w);
    return $clog2(2 * w);
  endfunction

  function automatic logic [31:0] jc_mask(input int w);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Legal words are a run of ones anchored at bit 0, or its complement.
  function automatic logic jc_legal(input logic [31:0] q, input int w);
    logic [31:0] m;
    logic [31:0] v;
    m = jc_mask(w);
    v = q[w-1] ? (~q & m) : (q & m);
    return (v & (v + 32'd1)) == 32'd0;
  endfunction

  function automatic int jc_decode(input logic [31:0] q, input int w);
    int pop;
    pop = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < w && q[i]) pop++;
    end
    return q[w-1] ? (2 * w - pop) : pop;
  endfunction

  function automatic logic [31:0] jc_next(input logic [31:0] q, input int w);
    return ((q << 1) | {31'd0, ~q[w-1]}) & jc_mask(w);
  endfunction

endpackage

// File: rtl/jcnt_code_decode.sv
// Combinational Johnson word classifier: legality flag and phase index.
module jcnt_code_decode
  import jcnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] q,
  output logic             legal,
  output logic [IW-1:0]    idx
);

  logic [31:0] qx;

  assign qx    = {{(32-WIDTH){1'b0}}, q};
  assign legal = jc_legal(qx, WIDTH);
  assign idx   = IW'(jc_decode(qx, WIDTH));

endmodule

// File: rtl/jcnt_rx.sv
// Johnson-code sequence monitor: decodes phase index, locks after LOCK_CNT successors,
// flags violations while locked. Optional macro JCNT_RX_STALL_EN accepts repeated words.
module jcnt_rx
  import jcnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  localparam int IW      = jc_iw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             valid_in,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  jc_state_e        state, state_n;
  logic [3:0]       match_cnt, match_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [IW-1:0]    idx_n;
  logic             idx_valid_n, err_n;
  logic [7:0]       err_cnt_n;

  logic             legal;
  logic [IW-1:0]    dec_idx;
  logic             is_succ, is_stall;

  jcnt_code_decode #(.WIDTH(WIDTH), .IW(IW)) u_dec (
    .q     (q_in),
    .legal (legal),
    .idx   (dec_idx)
  );

  assign is_succ = (q_in == WIDTH'(jc_next({{(32-WIDTH){1'b0}}, prev}, WIDTH)));

`ifdef JCNT_RX_STALL_EN
  assign is_stall = (q_in == prev);
`else
  assign is_stall = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    match_n     = match_cnt;
    prev_n      = prev;
    idx_n       = idx;
    idx_valid_n = 1'b0;
    err_n       = 1'b0;
    err_cnt_n   = err_cnt;
    if (valid_in) begin
      if (legal) begin
        idx_n       = dec_idx;
        idx_valid_n = 1'b1;
      end
      unique case (state)
        HUNT: begin
          if (legal) begin
            state_n = CONFIRM;
            match_n = 4'd1;
            prev_n  = q_in;
          end
        end
        CONFIRM: begin
          if (!legal) begin
            state_n = HUNT;
          end else if (is_succ) begin
            prev_n = q_in;
            // match_cnt counts the first sample, so lock once it has reached LOCK_CNT
            if (match_cnt >= 4'(LOCK_CNT)) state_n = LOCKED;
            else                           match_n = match_cnt + 4'd1;
          end else if (!is_stall) begin
            match_n = 4'd1;
            prev_n  = q_in;
          end
        end
        LOCKED: begin
          if (is_succ) begin
            prev_n = q_in;
          end else if (!is_stall) begin
            err_n = 1'b1;
            if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
            if (legal) begin
              state_n = CONFIRM;
              match_n = 4'd1;
              prev_n  = q_in;
            end else begin
              state_n = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      match_cnt <= '0;
      prev      <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      prev      <= prev_n;
      idx       <= idx_n;
      idx_valid <= idx_valid_n;
      err       <= err_n;
      err_cnt   <= err_cnt_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule
